axi_slave_mem_responder: RTL and testbench
==========================================

// Module: axi_slave_mem_responder
// PURPOSE
//  AXI4 slave endpoint directly downstream of axi_master_loader: accepts its AW/W/AR bursts, stores write data
//  in a word-addressed memory, returns B responses and R bursts with a programmable read latency.
//  Gives loader benches and NoC-port benches a deterministic, self-checking target; exposes burst counters/error flag.
// PARAMETERS
//  DATA_WIDTH    8    data bus width (bits); one memory word per beat
//  ADDR_WIDTH    16   address width
//  ID_W_WIDTH    5    AW/B id width
//  ID_R_WIDTH    5    AR/R id width
//  MEM_DEPTH     256  memory words (power of 2)
//  READ_LATENCY  2    idle cycles from AR handshake to first RVALID (0 allowed)
// PORTS
//  clk_i       in   1   clock, all logic on rising edge
//  arstn_i     in   1   reset, asynchronous, active-low
//  s_axi_i     if   -   axi_if slave side (AW/W/B/AR/R; params as above)
//  wr_count_o  out  16  completed write bursts (B handshakes), wraps at 2^16
//  rd_count_o  out  16  completed read bursts (last R handshake), wraps at 2^16
//  err_o       out  1   sticky protocol error flag
// BEHAVIOUR
//  Reset: all AXI outputs 0, counters 0, err_o 0, FSMs IDLE; memory NOT reset. Applies immediately, also mid-burst
//   (in-flight bursts dropped, memory kept). AWREADY/ARREADY are registered: 1 from first edge after release.
//  Index = (addr / (DATA_WIDTH/8)) mod MEM_DEPTH; wraps silently past MEM_DEPTH-1 -> 0.
//  Burst: AxBURST 00 FIXED (addr constant), 01 INCR (+1 word/beat), 10 WRAP -> treated as INCR, err_o<=1.
//   AxSIZE ignored (full width assumed). Beats = AxLEN+1 (1..256).
//  Write FSM W_IDLE -> W_DATA -> W_RESP:
//   W_IDLE: AWREADY=1; on AW handshake latch AWID/addr/len/burst, AWREADY<=0, -> W_DATA.
//   W_DATA: WREADY=1; per W handshake: if WSTRB, mem[idx]<=WDATA; advance addr, beat++.
//    Burst ends on final beat (beat==len) or WLAST, whichever first -> W_RESP. WLAST mismatch either way -> err_o<=1.
//   W_RESP: BVALID=1, BID=latched id, held until BREADY; on handshake wr_count++ , -> W_IDLE (AWREADY=1 next cycle).
//   Min write throughput: AW, beats, B on separate cycles; no AW accepted before previous B completes.
//  Read FSM R_IDLE -> R_WAIT -> R_DATA:
//   R_IDLE: ARREADY=1; on AR handshake latch ARID/addr/len/burst -> R_WAIT (READ_LATENCY=0 -> straight to R_DATA).
//   R_WAIT: count READ_LATENCY cycles, load rdata_q<=mem[idx], -> R_DATA.
//   R_DATA: RVALID=1, RDATA=rdata_q, RID=latched id, RLAST=(beat==len). RVALID/RDATA/RID/RLAST stable while !RREADY.
//    On handshake, non-last: advance addr, rdata_q<=mem[next idx], RVALID stays 1 (back-to-back beats).
//    Last: rd_count++, RVALID<=0, -> R_IDLE.
//  Read and write FSMs fully independent, may run concurrently. Same-cycle write and rdata_q load of the same index:
//   read returns OLD data; write visible to loads from next cycle.
//  Counters increment same edge as completing handshake; wrap 0xFFFF -> 0. err_o clears only on reset.
// TESTING
//  1 AW id=3 addr=0x0010 len=3 INCR, W A0..A3 (WLAST beat 3); AR id=3 same -> BID=3; R A0..A3, RLAST only beat 3,
//    RID=3; first RVALID 3 cycles after AR handshake (LAT=2); wr_count_o=1, rd_count_o=1, err_o=0.
//  2 Read len=3, RREADY low 5 cycles after beat 1 -> RVALID=1 and RDATA/RID/RLAST unchanged throughout; 4 beats total.
//  3 MEM_DEPTH=256: write len=1 at 0x00FF data 11,22 -> read 0x00FF len=1 returns 11,22; read 0x0000 returns 22.
//  4 AW len=3, WLAST on beat 1 -> B after 2 beats, err_o=1; AWBURST=10 -> err_o=1, behaves as INCR.
//  5 BREADY low 4 cycles -> BVALID/BID held, AWREADY=0 until B handshake; concurrent read completes meanwhile.
//  6 arstn_i low mid read burst (beat 2/8) -> RVALID=0 at once; after release ARREADY=1 next edge, counters 0,
//    earlier written data still read back.

Source files
------------

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave memory target: word-addressed store behind independent write and read FSMs,
// programmable read latency, completed-burst counters and a sticky protocol error flag.
module axi_slave_mem_responder #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int ID_W_WIDTH   = 5,
    parameter int ID_R_WIDTH   = 5,
    parameter int MEM_DEPTH    = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    // write address
    input  logic [ID_W_WIDTH-1:0]   s_axi_awid_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr_i,
    input  logic [7:0]              s_axi_awlen_i,
    input  logic [2:0]              s_axi_awsize_i,
    input  logic [1:0]              s_axi_awburst_i,
    input  logic                    s_axi_awvalid_i,
    output logic                    s_axi_awready_o,
    // write data
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb_i,
    input  logic                    s_axi_wlast_i,
    input  logic                    s_axi_wvalid_i,
    output logic                    s_axi_wready_o,
    // write response
    output logic [ID_W_WIDTH-1:0]   s_axi_bid_o,
    output logic [1:0]              s_axi_bresp_o,
    output logic                    s_axi_bvalid_o,
    input  logic                    s_axi_bready_i,
    // read address
    input  logic [ID_R_WIDTH-1:0]   s_axi_arid_i,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr_i,
    input  logic [7:0]              s_axi_arlen_i,
    input  logic [2:0]              s_axi_arsize_i,
    input  logic [1:0]              s_axi_arburst_i,
    input  logic                    s_axi_arvalid_i,
    output logic                    s_axi_arready_o,
    // read data
    output logic [ID_R_WIDTH-1:0]   s_axi_rid_o,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata_o,
    output logic [1:0]              s_axi_rresp_o,
    output logic                    s_axi_rlast_o,
    output logic                    s_axi_rvalid_o,
    input  logic                    s_axi_rready_i,
    // status
    output logic [15:0]             wr_count_o,
    output logic [15:0]             rd_count_o,
    output logic                    err_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Word index keeps only the bits that select a memory word, so wrap past MEM_DEPTH-1 is free.
    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write side ----------------
    logic [1:0]            wstate_q, wstate_d;
    logic                  awready_q, awready_d;
    logic [ID_W_WIDTH-1:0] wid_q, wid_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [7:0]            wbeat_q, wbeat_d;
    logic                  wfixed_q, wfixed_d;
    logic [15:0]           wr_count_q, wr_count_d;
    logic                  err_w;

    logic aw_hs, w_hs, b_hs, w_final;
    assign aw_hs   = s_axi_awvalid_i && awready_q;
    assign w_hs    = s_axi_wvalid_i && (wstate_q == W_DATA);
    assign b_hs    = s_axi_bready_i && (wstate_q == W_RESP);
    assign w_final = (wbeat_q == wlen_q);

    always_comb begin
        wstate_d   = wstate_q;
        awready_d  = awready_q;
        wid_d      = wid_q;
        widx_d     = widx_q;
        wlen_d     = wlen_q;
        wbeat_d    = wbeat_q;
        wfixed_d   = wfixed_q;
        wr_count_d = wr_count_q;
        err_w      = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (aw_hs) begin
                    wid_d     = s_axi_awid_i;
                    widx_d    = to_idx(s_axi_awaddr_i);
                    wlen_d    = s_axi_awlen_i;
                    wbeat_d   = 8'd0;
                    wfixed_d  = (s_axi_awburst_i == BURST_FIXED);
                    err_w     = (s_axi_awburst_i == BURST_WRAP);
                    awready_d = 1'b0;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    // An early or missing WLAST is flagged but still closes the burst on whichever comes first.
                    err_w = (w_final != s_axi_wlast_i);
                    if (w_final || s_axi_wlast_i) begin
                        wstate_d = W_RESP;
                    end else begin
                        wbeat_d = wbeat_q + 8'd1;
                        widx_d  = widx_q + IDX_W'(wfixed_q ? 0 : 1);
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wr_count_d = wr_count_q + 16'd1;
                    awready_d  = 1'b1;
                    wstate_d   = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wstate_q   <= W_IDLE;
            awready_q  <= 1'b0;
            wid_q      <= '0;
            widx_q     <= '0;
            wlen_q     <= '0;
            wbeat_q    <= '0;
            wfixed_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            wstate_q   <= wstate_d;
            awready_q  <= awready_d;
            wid_q      <= wid_d;
            widx_q     <= widx_d;
            wlen_q     <= wlen_d;
            wbeat_q    <= wbeat_d;
            wfixed_q   <= wfixed_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Storage is deliberately not reset so data survives a mid-burst reset.
    always_ff @(posedge clk_i) begin
        if (w_hs) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s_axi_wstrb_i[b]) mem[widx_q][b*8 +: 8] <= s_axi_wdata_i[b*8 +: 8];
            end
        end
    end

    // ---------------- read side ----------------
    logic [1:0]            rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic [ID_R_WIDTH-1:0] rid_q, rid_d;
    logic [IDX_W-1:0]      ridx_q, ridx_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [7:0]            rbeat_q, rbeat_d;
    logic                  rfixed_q, rfixed_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic                  err_r;
    logic [IDX_W-1:0]      ridx_nxt;

    logic ar_hs, r_hs;
    assign ar_hs    = s_axi_arvalid_i && arready_q;
    assign r_hs     = s_axi_rready_i && rvalid_q;
    assign ridx_nxt = ridx_q + IDX_W'(rfixed_q ? 0 : 1);

    always_comb begin
        rstate_d   = rstate_q;
        arready_d  = arready_q;
        rid_d      = rid_q;
        ridx_d     = ridx_q;
        rlen_d     = rlen_q;
        rbeat_d    = rbeat_q;
        rfixed_d   = rfixed_q;
        lat_d      = lat_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rd_count_d = rd_count_q;
        err_r      = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rid_d     = s_axi_arid_i;
                    ridx_d    = to_idx(s_axi_araddr_i);
                    rlen_d    = s_axi_arlen_i;
                    rbeat_d   = 8'd0;
                    rfixed_d  = (s_axi_arburst_i == BURST_FIXED);
                    err_r     = (s_axi_arburst_i == BURST_WRAP);
                    lat_d     = '0;
                    arready_d = 1'b0;
                    if (READ_LATENCY == 0) begin
                        rdata_d  = mem[to_idx(s_axi_araddr_i)];
                        rvalid_d = 1'b1;
                        rstate_d = R_DATA;
                    end else begin
                        rstate_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (int'(lat_q) == READ_LATENCY - 1) begin
                    rdata_d  = mem[ridx_q];
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rbeat_q == rlen_q) begin
                        rvalid_d   = 1'b0;
                        rd_count_d = rd_count_q + 16'd1;
                        arready_d  = 1'b1;
                        rstate_d   = R_IDLE;
                    end else begin
                        // Prefetch the next word so beats stream back-to-back.
                        ridx_d  = ridx_nxt;
                        rdata_d = mem[ridx_nxt];
                        rbeat_d = rbeat_q + 8'd1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rstate_q   <= R_IDLE;
            arready_q  <= 1'b0;
            rid_q      <= '0;
            ridx_q     <= '0;
            rlen_q     <= '0;
            rbeat_q    <= '0;
            rfixed_q   <= 1'b0;
            lat_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rd_count_q <= '0;
        end else begin
            rstate_q   <= rstate_d;
            arready_q  <= arready_d;
            rid_q      <= rid_d;
            ridx_q     <= ridx_d;
            rlen_q     <= rlen_d;
            rbeat_q    <= rbeat_d;
            rfixed_q   <= rfixed_d;
            lat_q      <= lat_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rd_count_q <= rd_count_d;
        end
    end

    // ---------------- shared status ----------------
    logic err_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) err_q <= 1'b0;
        else          err_q <= err_q | err_w | err_r;
    end

    assign s_axi_awready_o = awready_q;
    assign s_axi_wready_o  = (wstate_q == W_DATA);
    assign s_axi_bvalid_o  = (wstate_q == W_RESP);
    assign s_axi_bid_o     = (wstate_q == W_RESP) ? wid_q : '0;
    assign s_axi_bresp_o   = 2'b00;

    assign s_axi_arready_o = arready_q;
    assign s_axi_rvalid_o  = rvalid_q;
    assign s_axi_rdata_o   = rvalid_q ? rdata_q : '0;
    assign s_axi_rid_o     = rvalid_q ? rid_q : '0;
    assign s_axi_rlast_o   = rvalid_q && (rbeat_q == rlen_q);
    assign s_axi_rresp_o   = 2'b00;

    assign wr_count_o = wr_count_q;
    assign rd_count_o = rd_count_q;
    assign err_o      = err_q;

    // Transfer size is assumed full-width; address bits above the word index are don't-care.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awsize_i, s_axi_arsize_i, s_axi_awaddr_i, s_axi_araddr_i};

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Scoreboard bench for axi_slave_mem_responder: a byte model of the memory predicts every B and R beat.
module tb_axi_slave_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  aw_id;    logic [15:0] aw_addr;  logic [7:0] aw_len;
    logic [2:0]  aw_size;  logic [1:0]  aw_burst; logic aw_valid; logic aw_ready;
    logic [7:0]  w_data;   logic [0:0]  w_strb;   logic w_last;   logic w_valid; logic w_ready;
    logic [4:0]  b_id;     logic [1:0]  b_resp;   logic b_valid;  logic b_ready;
    logic [4:0]  ar_id;    logic [15:0] ar_addr;  logic [7:0] ar_len;
    logic [2:0]  ar_size;  logic [1:0]  ar_burst; logic ar_valid; logic ar_ready;
    logic [4:0]  r_id;     logic [7:0]  r_data;   logic [1:0] r_resp;
    logic        r_last;   logic        r_valid;  logic r_ready;
    logic [15:0] wr_count, rd_count;
    logic        err;

    axi_slave_mem_responder #(.READ_LATENCY(LAT)) dut (
        .clk_i(clk), .arstn_i(rstn),
        .s_axi_awid_i(aw_id), .s_axi_awaddr_i(aw_addr), .s_axi_awlen_i(aw_len),
        .s_axi_awsize_i(aw_size), .s_axi_awburst_i(aw_burst), .s_axi_awvalid_i(aw_valid),
        .s_axi_awready_o(aw_ready),
        .s_axi_wdata_i(w_data), .s_axi_wstrb_i(w_strb), .s_axi_wlast_i(w_last),
        .s_axi_wvalid_i(w_valid), .s_axi_wready_o(w_ready),
        .s_axi_bid_o(b_id), .s_axi_bresp_o(b_resp), .s_axi_bvalid_o(b_valid), .s_axi_bready_i(b_ready),
        .s_axi_arid_i(ar_id), .s_axi_araddr_i(ar_addr), .s_axi_arlen_i(ar_len),
        .s_axi_arsize_i(ar_size), .s_axi_arburst_i(ar_burst), .s_axi_arvalid_i(ar_valid),
        .s_axi_arready_o(ar_ready),
        .s_axi_rid_o(r_id), .s_axi_rdata_o(r_data), .s_axi_rresp_o(r_resp), .s_axi_rlast_o(r_last),
        .s_axi_rvalid_o(r_valid), .s_axi_rready_i(r_ready),
        .wr_count_o(wr_count), .rd_count_o(rd_count), .err_o(err)
    );

    typedef struct packed {
        logic       last;
        logic [4:0] id;
        logic [7:0] data;
    } rexp_t;

    rexp_t      rq[$];
    logic [4:0] bq[$];
    logic [7:0] ref_mem [DEPTH];
    int         errors = 0;
    int         checks = 0;
    int         exp_wr = 0;
    int         exp_rd = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on each handshake and checks holds while stalled.
    logic        r_stall = 1'b0, b_stall = 1'b0;
    logic [13:0] r_snap;
    logic [4:0]  b_snap;
    always @(negedge clk) begin
        if (!rstn) begin
            r_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (r_stall) begin
                chk("r_hold_valid", r_valid, 1);
                chk("r_hold_bus", {r_data, r_id, r_last}, r_snap);
            end
            if (b_stall) begin
                chk("b_hold_valid", b_valid, 1);
                chk("b_hold_id", b_id, b_snap);
            end
            if (r_valid && r_ready) begin
                if (rq.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("rdata", r_data, e.data);
                    chk("rid", r_id, e.id);
                    chk("rlast", r_last, e.last);
                end
            end
            if (b_valid && b_ready) begin
                if (bq.size() == 0) chk("b_unexpected", 1, 0);
                else chk("bid", b_id, bq.pop_front());
            end
            r_stall = r_valid && !r_ready;
            r_snap  = {r_data, r_id, r_last};
            b_stall = b_valid && !b_ready;
            b_snap  = b_id;
        end
    end

    task automatic reset_pulse();
        rstn = 1'b0;
        aw_valid = 0; w_valid = 0; w_last = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
        #1;
        chk("rst_rvalid", r_valid, 0);
        chk("rst_bvalid", b_valid, 0);
        chk("rst_wready", w_ready, 0);
        chk("rst_awready", aw_ready, 0);
        chk("rst_arready", ar_ready, 0);
        @(posedge clk); #1;
        chk("rst_wr_count", wr_count, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_err", err, 0);
        rstn = 1'b1;
        #1;
        chk("rel_arready_pre", ar_ready, 0);
        @(posedge clk); #1;
        chk("rel_arready", ar_ready, 1);
        chk("rel_awready", aw_ready, 1);
        exp_wr = 0;
        exp_rd = 0;
    endtask

    task automatic axi_write(input logic [4:0] id, input logic [15:0] addr, input int len,
                             input logic [1:0] burst, input logic [7:0] base, input logic [7:0] step,
                             input int wlast_at, input int bdelay);
        int idx, nb, to;
        logic [7:0] d;
        idx = addr % DEPTH;
        nb  = ((wlast_at < len) ? wlast_at : len) + 1;
        @(posedge clk); #1;
        aw_id = id; aw_addr = addr; aw_len = 8'(len); aw_burst = burst; aw_size = 3'd0; aw_valid = 1;
        to = 0;
        do begin @(negedge clk); to++; end while (!aw_ready && to < 200);
        if (!aw_ready) chk("tmo_aw", 0, 1);
        @(posedge clk); #1 aw_valid = 0;
        for (int b = 0; b < nb; b++) begin
            d = base + 8'(b * step);
            w_data = d; w_strb = 1'b1; w_last = (b == wlast_at); w_valid = 1;
            to = 0;
            do begin @(negedge clk); to++; end while (!w_ready && to < 200);
            if (!w_ready) chk("tmo_w", 0, 1);
            ref_mem[idx] = d;
            if (burst != 2'b00) idx = (idx + 1) % DEPTH;
            @(posedge clk); #1;
        end
        w_valid = 0; w_last = 0;
        bq.push_back(id);
        to = 0;
        do begin @(negedge clk); to++; end while (!b_valid && to < 200);
        if (!b_valid) chk("tmo_b", 0, 1);
        for (int i = 0; i < bdelay; i++) begin
            chk("aw_blocked", aw_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 b_ready = 1;
        @(posedge clk); #1 b_ready = 0;
        exp_wr++;
        chk("awready_after_b", aw_ready, 1);
        chk("wr_count", wr_count, exp_wr);
    endtask

    task automatic axi_read(input logic [4:0] id, input logic [15:0] addr, input int len,
                            input logic [1:0] burst, input int stall_beat, input int stall_n,
                            input int abort_at, input bit chk_lat);
        int idx, nexp, nb, cyc, to;
        rexp_t e;
        idx  = addr % DEPTH;
        nexp = (abort_at >= 0 && abort_at <= len) ? abort_at : len + 1;
        for (int b = 0; b < nexp; b++) begin
            e.last = (b == len); e.id = id; e.data = ref_mem[idx];
            rq.push_back(e);
            if (burst != 2'b00) idx = (idx + 1) % DEPTH;
        end
        @(posedge clk); #1;
        r_ready = 1;
        ar_id = id; ar_addr = addr; ar_len = 8'(len); ar_burst = burst; ar_size = 3'd0; ar_valid = 1;
        to = 0;
        do begin @(negedge clk); to++; end while (!ar_ready && to < 200);
        if (!ar_ready) chk("tmo_ar", 0, 1);
        @(posedge clk); #1 ar_valid = 0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!r_valid && cyc < 200);
        if (chk_lat) chk("rd_latency", cyc, LAT + 1);
        nb = 0; to = 0;
        while (nb < nexp && to < 1000) begin
            if (r_valid && r_ready) begin
                nb++;
                if (nb - 1 == stall_beat) begin
                    @(posedge clk); #1 r_ready = 0;
                    repeat (stall_n) @(posedge clk);
                    #1 r_ready = 1;
                end
            end
            if (nb < nexp) begin @(negedge clk); to++; end
        end
        if (nb < nexp) chk("tmo_r_beats", nb, nexp);
        @(posedge clk); #1;
        if (abort_at < 0) begin
            r_ready = 0;
            exp_rd++;
            chk("rd_count", rd_count, exp_rd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0; aw_valid = 0;
        w_data = 0; w_strb = 0; w_last = 0; w_valid = 0; b_ready = 0;
        ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; ar_valid = 0; r_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset_pulse();

        // basic INCR write/read with latency measurement
        axi_write(5'd3, 16'h0010, 3, 2'b01, 8'hA0, 8'h01, 3, 0);
        axi_read(5'd3, 16'h0010, 3, 2'b01, -1, 0, -1, 1);
        chk("err_clean_1", err, 0);

        // RREADY stall after beat 1
        axi_read(5'd4, 16'h0010, 3, 2'b01, 1, 5, -1, 0);

        // index wrap at the top of memory
        axi_write(5'd5, 16'h00FF, 1, 2'b01, 8'h11, 8'h11, 1, 0);
        axi_read(5'd5, 16'h00FF, 1, 2'b01, -1, 0, -1, 0);
        axi_read(5'd6, 16'h0000, 0, 2'b01, -1, 0, -1, 0);

        // FIXED bursts hammer a single word
        axi_write(5'd1, 16'h0070, 2, 2'b00, 8'h31, 8'h01, 2, 0);
        axi_read(5'd1, 16'h0070, 2, 2'b00, -1, 0, -1, 0);
        axi_read(5'd2, 16'h0070, 0, 2'b01, -1, 0, -1, 0);
        chk("err_clean_2", err, 0);

        // early WLAST ends the burst and flags an error
        axi_write(5'd8, 16'h0050, 3, 2'b01, 8'h51, 8'h01, 1, 0);
        chk("err_early_wlast", err, 1);
        axi_read(5'd8, 16'h0050, 1, 2'b01, -1, 0, -1, 0);

        // WRAP is flagged and handled as INCR
        reset_pulse();
        axi_write(5'd2, 16'h0060, 2, 2'b10, 8'h61, 8'h01, 2, 0);
        chk("err_wrap", err, 1);
        axi_read(5'd2, 16'h0060, 2, 2'b01, -1, 0, -1, 0);

        // held B response with a concurrent read (data survived the reset)
        fork
            axi_write(5'd7, 16'h0030, 1, 2'b01, 8'h71, 8'h01, 1, 4);
            begin
                repeat (2) @(posedge clk);
                axi_read(5'd9, 16'h0010, 3, 2'b01, -1, 0, -1, 0);
            end
        join

        // reset in the middle of an 8-beat read
        axi_write(5'd10, 16'h0090, 7, 2'b01, 8'hC0, 8'h01, 7, 0);
        axi_read(5'd11, 16'h0090, 7, 2'b01, -1, 0, 2, 0);
        chk("r_valid_pre_reset", r_valid, 1);
        reset_pulse();
        axi_read(5'd12, 16'h0090, 7, 2'b01, -1, 0, -1, 0);
        axi_read(5'd13, 16'h0010, 3, 2'b01, -1, 0, -1, 0);

        repeat (3) @(posedge clk);
        chk("sb_r_empty", rq.size(), 0);
        chk("sb_b_empty", bq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
